uart_alu_frame_ctrl: RTL and testbench

UART_ALU_FRAME_CTRL -- requirements
Module: uart_alu_frame_ctrl

---
 rtl/uart_alu_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_uart_alu_frame_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_frame_ctrl.sv
// UART framing controller for an external ALU.
// Receives NB bytes of A, NB bytes of B, then one opcode byte (LSB byte first).
// Captures the ALU result and sends it back byte by byte, optionally followed
// by a status byte. A partial frame that stalls for TIMEOUT_CYC cycles is aborted.
module uart_alu_frame_ctrl #(
   parameter int DATA_W      = 32,
   parameter int OP_W        = 6,
   parameter int TIMEOUT_CYC = 100000,
   parameter int STATUS_EN   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        d_in,
   input  logic              rx_done,
   input  logic              tx_done,
   input  logic [DATA_W-1:0] d_out_ALU,
   output logic [7:0]        d_out,
   output logic              tx_start,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [OP_W-1:0]   opcode,
   output logic              busy,
   output logic              frame_err,
   output logic              overrun
);
   localparam int NB  = DATA_W / 8;
   localparam int CW  = $clog2(NB + 1);
   localparam int TW  = $clog2(TIMEOUT_CYC);
   localparam int TXN = NB + ((STATUS_EN != 0) ? 1 : 0);

   typedef enum logic [2:0] {RX_A, RX_B, RX_OP, EXEC, TX_LOAD, TX_WAIT} state_t;

   state_t            r_state, w_next;
   logic [CW-1:0]     r_cnt, w_cnt_inc;
   logic [TW-1:0]     r_tmo;
   logic [DATA_W-1:0] r_a, r_b, r_result;
   logic [OP_W-1:0]   r_op;
   logic [7:0]        r_dout, w_tx_byte, w_status;
   logic              r_frame_err, r_overrun, r_fe_seen;
   logic              w_rx_last, w_tx_last, w_tmo_en, w_abort, w_in_exec_tx;

   assign w_cnt_inc    = r_cnt + CW'(1);
   assign w_rx_last    = (r_cnt == CW'(NB - 1));
   // compare against the last index so the counter never has to hold NB+1
   assign w_tx_last    = (r_cnt == CW'(TXN - 1));
   assign w_tmo_en     = ((r_state == RX_A) && (r_cnt != '0)) ||
                         (r_state == RX_B) || (r_state == RX_OP);
   // a byte arriving on the terminal cycle rescues the frame
   assign w_abort      = w_tmo_en && !rx_done && (r_tmo == TW'(TIMEOUT_CYC - 1));
   assign w_in_exec_tx = (r_state == EXEC) || (r_state == TX_LOAD) || (r_state == TX_WAIT);
   assign w_status     = {6'b0, r_overrun, r_fe_seen};

   // select the next byte to transmit: result byte, or status after the last one
   always_comb begin
      w_tx_byte = w_status;
      for (int i = 0; i < NB; i++)
         if (w_cnt_inc == CW'(i)) w_tx_byte = r_result[i*8 +: 8];
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         RX_A:    if (rx_done && w_rx_last) w_next = RX_B;
         RX_B:    if (rx_done && w_rx_last) w_next = RX_OP;
                  else if (w_abort)         w_next = RX_A;
         RX_OP:   if (rx_done)              w_next = EXEC;
                  else if (w_abort)         w_next = RX_A;
         EXEC:    w_next = TX_LOAD;
         TX_LOAD: w_next = TX_WAIT;
         TX_WAIT: if (tx_done)              w_next = w_tx_last ? RX_A : TX_LOAD;
         default: w_next = RX_A;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= RX_A;
      else        r_state <= w_next;
   end

   // byte counter, timeout, operand/result capture, transmit byte and flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt       <= '0;
         r_tmo       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_result    <= '0;
         r_dout      <= '0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_fe_seen   <= 1'b0;
      end else begin
         r_frame_err <= w_abort;
         if (w_abort) r_fe_seen <= 1'b1;
         if (rx_done && w_in_exec_tx) r_overrun <= 1'b1;

         if (rx_done || !w_tmo_en || w_abort) r_tmo <= '0;
         else                                 r_tmo <= r_tmo + TW'(1);

         case (r_state)
            RX_A, RX_B: begin
               if (rx_done) begin
                  for (int i = 0; i < NB; i++) begin
                     if (r_cnt == CW'(i)) begin
                        if (r_state == RX_A) r_a[i*8 +: 8] <= d_in;
                        else                 r_b[i*8 +: 8] <= d_in;
                     end
                  end
                  r_cnt <= w_rx_last ? '0 : w_cnt_inc;
               end else if (w_abort) begin
                  r_cnt <= '0;
               end
            end
            RX_OP: if (rx_done) r_op <= d_in[OP_W-1:0];
            EXEC: begin
               // byte 0 is staged here so d_out is valid during the tx_start cycle
               r_result <= d_out_ALU;
               r_dout   <= d_out_ALU[7:0];
               r_cnt    <= '0;
            end
            TX_WAIT: begin
               if (tx_done) begin
                  r_cnt <= w_tx_last ? '0 : w_cnt_inc;
                  if (!w_tx_last) r_dout <= w_tx_byte;
                  if ((STATUS_EN != 0) && w_tx_last) r_fe_seen <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign d_out     = r_dout;
   assign tx_start  = (r_state == TX_LOAD);
   assign A         = r_a;
   assign B         = r_b;
   assign opcode    = r_op;
   assign busy      = (r_state != RX_A) || (r_cnt != '0);
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Bench for uart_alu_frame_ctrl: three instances (16/8/64-bit operands) driven
// through directed and randomized frames, checked against a byte-level model.
module tb_uart_alu_frame_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn [3];
   logic       rxd  [3];
   logic       txd  [3];
   logic [7:0] din  [3];
   logic [7:0] dout [3];
   logic       txs  [3];
   logic       bsy  [3];
   logic       fe   [3];
   logic       ov   [3];

   logic [15:0] a16, b16;
   logic [7:0]  a8, b8;
   logic [63:0] a64, b64;
   logic [5:0]  op16, op8, op64;

   // external ALU model: addition, truncated to the operand width
   wire [15:0] alu16 = a16 + b16;
   wire [7:0]  alu8  = a8 + b8;
   wire [63:0] alu64 = a64 + b64;

   uart_alu_frame_ctrl #(.DATA_W(16), .OP_W(6), .TIMEOUT_CYC(50), .STATUS_EN(1)) u16 (
      .clk(clk), .reset(rstn[0]), .d_in(din[0]), .rx_done(rxd[0]), .tx_done(txd[0]),
      .d_out_ALU(alu16), .d_out(dout[0]), .tx_start(txs[0]), .A(a16), .B(b16),
      .opcode(op16), .busy(bsy[0]), .frame_err(fe[0]), .overrun(ov[0]));
   uart_alu_frame_ctrl #(.DATA_W(8), .OP_W(6), .TIMEOUT_CYC(50), .STATUS_EN(1)) u8 (
      .clk(clk), .reset(rstn[1]), .d_in(din[1]), .rx_done(rxd[1]), .tx_done(txd[1]),
      .d_out_ALU(alu8), .d_out(dout[1]), .tx_start(txs[1]), .A(a8), .B(b8),
      .opcode(op8), .busy(bsy[1]), .frame_err(fe[1]), .overrun(ov[1]));
   uart_alu_frame_ctrl #(.DATA_W(64), .OP_W(6), .TIMEOUT_CYC(50), .STATUS_EN(1)) u64 (
      .clk(clk), .reset(rstn[2]), .d_in(din[2]), .rx_done(rxd[2]), .tx_done(txd[2]),
      .d_out_ALU(alu64), .d_out(dout[2]), .tx_start(txs[2]), .A(a64), .B(b64),
      .opcode(op64), .busy(bsy[2]), .frame_err(fe[2]), .overrun(ov[2]));

   int   ncmp = 0;
   int   nerr = 0;
   int   fe_cnt [3];
   logic m_ov [3];
   logic m_fe [3];

   function automatic int nbytes(input int s);
      case (s)
         0:       return 2;
         1:       return 1;
         default: return 8;
      endcase
   endfunction

   function automatic logic [63:0] wmask(input int s);
      if (nbytes(s) == 8) return '1;
      return (64'd1 << (8 * nbytes(s))) - 64'd1;
   endfunction

   function automatic logic [63:0] get_a(input int s);
      case (s)
         0:       return {48'b0, a16};
         1:       return {56'b0, a8};
         default: return a64;
      endcase
   endfunction

   function automatic logic [63:0] get_b(input int s);
      case (s)
         0:       return {48'b0, b16};
         1:       return {56'b0, b8};
         default: return b64;
      endcase
   endfunction

   function automatic logic [63:0] get_op(input int s);
      case (s)
         0:       return {58'b0, op16};
         1:       return {58'b0, op8};
         default: return {58'b0, op64};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // advance to the next falling edge, tallying frame_err pulses
   task automatic step(input int s);
      @(negedge clk);
      if (fe[s] === 1'b1) fe_cnt[s]++;
   endtask

   task automatic send_byte(input int s, input logic [7:0] v, input int gap);
      rxd[s] = 1'b1;
      din[s] = v;
      step(s);
      rxd[s] = 1'b0;
      repeat (gap) step(s);
   endtask

   task automatic wait_tx(input int s);
      int k = 0;
      while (txs[s] !== 1'b1 && k < 20) begin
         step(s);
         k++;
      end
      chk("tx_start_seen", {63'b0, txs[s]}, 64'd1);
   endtask

   // send a whole frame, then check operands, latency and every transmitted byte
   task automatic run_frame(input int s, input logic [63:0] a, input logic [63:0] b,
                            input logic [7:0] op, input int inj, input int gapmax,
                            input int gap_b0);
      int nb = nbytes(s);
      logic [63:0] am, bm, sum;
      logic [7:0]  exp;
      am  = a & wmask(s);
      bm  = b & wmask(s);
      sum = (am + bm) & wmask(s);
      for (int i = 0; i < nb; i++) begin
         send_byte(s, am[8*i +: 8], $urandom_range(gapmax, 0));
         if (i == 0) chk("busy_rx", {63'b0, bsy[s]}, 64'd1);
      end
      for (int i = 0; i < nb; i++)
         send_byte(s, bm[8*i +: 8], (i == 0 && gap_b0 >= 0) ? gap_b0 : $urandom_range(gapmax, 0));
      send_byte(s, op, 0);
      chk("lat_exec_no_tx", {63'b0, txs[s]}, 64'd0);
      step(s);
      chk("lat_tx_start", {63'b0, txs[s]}, 64'd1);
      chk("reg_A", get_a(s), am);
      chk("reg_B", get_b(s), bm);
      chk("reg_opcode", get_op(s), {58'b0, op[5:0]});
      for (int i = 0; i <= nb; i++) begin
         if (i > 0) wait_tx(s);
         exp = (i < nb) ? sum[8*i +: 8] : {6'b0, m_ov[s], m_fe[s]};
         chk((i < nb) ? "tx_result_byte" : "tx_status_byte", {56'b0, dout[s]}, {56'b0, exp});
         step(s);
         chk("tx_start_pulse", {63'b0, txs[s]}, 64'd0);
         if (i == inj) begin
            rxd[s] = 1'b1;
            din[s] = 8'h55;
            step(s);
            rxd[s] = 1'b0;
            m_ov[s] = 1'b1;
            chk("overrun_set", {63'b0, ov[s]}, 64'd1);
         end
         repeat ($urandom_range(2, 0)) step(s);
         chk("tx_hold", {56'b0, dout[s]}, {56'b0, exp});
         txd[s] = 1'b1;
         step(s);
         txd[s] = 1'b0;
         if (i == nb) m_fe[s] = 1'b0;
      end
      chk("busy_idle", {63'b0, bsy[s]}, 64'd0);
      step(s);
      chk("no_extra_tx", {63'b0, txs[s]}, 64'd0);
   endtask

   task automatic chk_reset(input int s);
      chk("rst_dout", {56'b0, dout[s]}, 64'd0);
      chk("rst_tx_start", {63'b0, txs[s]}, 64'd0);
      chk("rst_busy", {63'b0, bsy[s]}, 64'd0);
      chk("rst_frame_err", {63'b0, fe[s]}, 64'd0);
      chk("rst_overrun", {63'b0, ov[s]}, 64'd0);
      chk("rst_A", get_a(s), 64'd0);
      chk("rst_B", get_b(s), 64'd0);
      chk("rst_opcode", get_op(s), 64'd0);
   endtask

   initial begin
      int first;
      for (int s = 0; s < 3; s++) begin
         rstn[s] = 1'b0; rxd[s] = 1'b0; txd[s] = 1'b0; din[s] = 8'h00;
         fe_cnt[s] = 0; m_ov[s] = 1'b0; m_fe[s] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) chk_reset(s);
      for (int s = 0; s < 3; s++) rstn[s] = 1'b1;
      @(negedge clk);

      // basic frame: 0x1234 + 0x0001
      run_frame(0, 64'h1234, 64'h0001, 8'h20, -1, 0, -1);

      // timeout after a partial frame
      send_byte(0, 8'h34, 0);
      send_byte(0, 8'h12, 0);
      send_byte(0, 8'h01, 0);
      fe_cnt[0] = 0;
      first = -1;
      for (int k = 1; k <= 60; k++) begin
         step(0);
         if (fe[0] === 1'b1 && first < 0) first = k;
      end
      m_fe[0] = 1'b1;
      chk("tmo_first_cycle", 64'(first), 64'd50);
      chk("tmo_pulse_count", 64'(fe_cnt[0]), 64'd1);
      chk("tmo_busy", {63'b0, bsy[0]}, 64'd0);
      chk("tmo_keep_A", {48'b0, a16}, 64'h1234);
      run_frame(0, 64'h00FF, 64'h0001, 8'h20, -1, 0, -1);

      // overrun during TX_WAIT, then a normal frame afterwards
      run_frame(0, 64'h0102, 64'h0304, 8'h07, 0, 2, -1);
      run_frame(0, 64'hABCD, 64'h1111, 8'hC3, -1, 2, -1);

      // byte on the timeout terminal cycle in RX_B is accepted
      fe_cnt[0] = 0;
      run_frame(0, 64'h2211, 64'h4433, 8'h05, -1, 0, 49);
      chk("simul_no_frame_err", 64'(fe_cnt[0]), 64'd0);

      // randomized frames
      for (int n = 0; n < 4; n++)
         run_frame(0, {32'b0, $urandom}, {32'b0, $urandom}, 8'($urandom), -1, 5, -1);

      // reset during TX_WAIT after the first byte
      send_byte(0, 8'h78, 0);
      send_byte(0, 8'h56, 0);
      send_byte(0, 8'h11, 0);
      send_byte(0, 8'h11, 0);
      send_byte(0, 8'h2A, 0);
      wait_tx(0);
      chk("rst_mid_byte0", {56'b0, dout[0]}, 64'h89);
      step(0);
      rstn[0] = 1'b0;
      #1;
      chk_reset(0);
      for (int k = 0; k < 3; k++) begin
         txd[0] = (k == 1);
         step(0);
         chk("rst_no_tx", {63'b0, txs[0]}, 64'd0);
      end
      txd[0] = 1'b0;
      rstn[0] = 1'b1;
      m_ov[0] = 1'b0;
      m_fe[0] = 1'b0;
      step(0);
      run_frame(0, 64'h0F0F, 64'h0101, 8'h3F, -1, 1, -1);

      // width sweep
      run_frame(1, 64'hFF, 64'hFF, 8'h01, -1, 1, -1);
      run_frame(1, {56'b0, 8'($urandom)}, {56'b0, 8'($urandom)}, 8'($urandom), -1, 2, -1);
      run_frame(2, '1, '1, 8'h01, -1, 1, -1);
      run_frame(2, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 3, 2, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
